// File: rtl/tmr_mem_scrub_ctrl.sv
// Shares one TMR memory port between a host and a background scrubber doing atomic voted-read/writeback pairs.
// Host wins by default; a pending scrub overrides it after MAX_WAIT blocked grants, costing the host at most 3 cycles.
module tmr_mem_scrub_ctrl #(
    parameter int AW           = 8,
    parameter int DW           = 8,
    parameter int SCRUB_PERIOD = 64,
    parameter int MAX_WAIT     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scrub_en,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] scrub_addr,
    output logic          busy,
    output logic          pass_done,
    output logic [15:0]   pass_cnt
);
    localparam int TW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SCRUB_PERIOD - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, S_RD, S_WB} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pending_q, pending_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [AW-1:0] scrub_addr_q, scrub_addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [15:0]   pass_cnt_q, pass_cnt_d;
    logic          rvalid_q, rvalid_d;
    logic          tick;
    logic          scrub_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            pending_q    <= 1'b0;
            starve_q     <= '0;
            scrub_addr_q <= '0;
            data_q       <= '0;
            pass_cnt_q   <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            starve_q     <= starve_d;
            scrub_addr_q <= scrub_addr_d;
            data_q       <= data_d;
            pass_cnt_q   <= pass_cnt_d;
            rvalid_q     <= rvalid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pending_d    = pending_q;
        starve_d     = starve_q;
        scrub_addr_d = scrub_addr_q;
        data_d       = data_q;
        pass_cnt_d   = pass_cnt_q;
        rvalid_d     = 1'b0;
        host_gnt     = 1'b0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        pass_done    = 1'b0;

        tick      = scrub_en && (timer_q == TIMER_LAST);
        scrub_win = pending_q && (!host_req || (starve_q >= STARVE_MAX));

        if (!scrub_en || tick) timer_d = '0;
        else                   timer_d = timer_q + 1'b1;

        case (state_q)
            IDLE: begin
                // rst_n gating keeps the memory strobes quiet while reset is held
                if (rst_n && scrub_win) begin
                    mem_re    = 1'b1;
                    mem_addr  = scrub_addr_q;
                    pending_d = 1'b0;
                    starve_d  = '0;
                    state_d   = S_RD;
                end else if (rst_n && host_req) begin
                    host_gnt = 1'b1;
                    mem_addr = host_addr;
                    if (host_we) begin
                        mem_we    = 1'b1;
                        mem_wdata = host_wdata;
                    end else begin
                        mem_re   = 1'b1;
                        rvalid_d = 1'b1;
                    end
                    if (pending_q && (starve_q != STARVE_MAX)) starve_d = starve_q + 1'b1;
                end
            end
            S_RD: begin
                data_d  = mem_rdata;
                state_d = S_WB;
            end
            S_WB: begin
                mem_we       = 1'b1;
                mem_addr     = scrub_addr_q;
                mem_wdata    = data_q;
                scrub_addr_d = scrub_addr_q + 1'b1;
                if (scrub_addr_q == '1) begin
                    pass_done  = 1'b1;
                    pass_cnt_d = pass_cnt_q + 16'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A tick landing on the cycle the scrub wins re-arms pending rather than being lost.
        if (tick) pending_d = 1'b1;
        if (!scrub_en) begin
            pending_d = 1'b0;
            starve_d  = '0;
        end
    end

    assign host_rvalid = rvalid_q;
    assign host_rdata  = mem_rdata;
    assign scrub_addr  = scrub_addr_q;
    assign busy        = (state_q != IDLE);
    assign pass_cnt    = pass_cnt_q;

endmodule

// File: tb/tb_tmr_mem_scrub_ctrl.sv
// Bench for tmr_mem_scrub_ctrl: TMR memory model, shadow-memory scoreboard, directed scenarios, random host/scrub traffic.
module tb_tmr_mem_scrub_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int SP = 4;
    localparam int MW = 3;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scrub_en = 1'b0;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_gnt, host_rvalid, mem_we, mem_re, busy, pass_done;
    logic [DW-1:0] host_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr, scrub_addr;
    logic [15:0]   pass_cnt;

    logic          inj_vld = 1'b0;
    logic [AW-1:0] inj_addr = '0;
    logic [DW-1:0] inj_d0 = '0, inj_d1 = '0, inj_d2 = '0;
    logic [DW-1:0] cp0 [N];
    logic [DW-1:0] cp1 [N];
    logic [DW-1:0] cp2 [N];
    logic [DW-1:0] rdata_q;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DW-1:0] shadow [N];
    int            exp_scrub = 0;
    int            exp_pass  = 0;
    bit            exp_rv    = 0;
    logic [DW-1:0] exp_rd    = '0;
    int            wait_cnt  = 0;

    bit   ok, found, g;
    int   prev, pd_cnt;
    logic [DW-1:0] d;

    tmr_mem_scrub_ctrl #(.AW(AW), .DW(DW), .SCRUB_PERIOD(SP), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .scrub_addr(scrub_addr), .busy(busy),
        .pass_done(pass_done), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] maj(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [DW-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            cp0[mem_addr] <= mem_wdata;
            cp1[mem_addr] <= mem_wdata;
            cp2[mem_addr] <= mem_wdata;
        end
        if (inj_vld) begin
            cp0[inj_addr] <= inj_d0;
            cp1[inj_addr] <= inj_d1;
            cp2[inj_addr] <= inj_d2;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rdata_q <= '0;
        else if (mem_re) rdata_q <= maj(cp0[mem_addr], cp1[mem_addr], cp2[mem_addr]);
    end
    assign mem_rdata = rdata_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: memory contents as the host sees them, plus the scrub walk and pass count.
    task automatic monitor();
        bit srd, swb;
        if (inj_vld) shadow[inj_addr] = maj(inj_d0, inj_d1, inj_d2);
        if (!rst_n) begin
            exp_scrub = 0;
            exp_pass  = 0;
            exp_rv    = 0;
            wait_cnt  = 0;
            return;
        end
        chk("we_re_excl", 32'(mem_we & mem_re), 0);
        chk("gnt_outside_idle", 32'(host_gnt & busy), 0);
        chk("host_rvalid", 32'(host_rvalid), 32'(exp_rv));
        if (exp_rv) chk("host_rdata", 32'(host_rdata), 32'(exp_rd));
        exp_rv = 0;
        if (host_gnt) begin
            chk("host_wait_bound", 32'(wait_cnt <= 3), 1);
            wait_cnt = 0;
            chk("gnt_addr", 32'(mem_addr), 32'(host_addr));
            chk("gnt_op", 32'({mem_we, mem_re}), host_we ? 2 : 1);
            if (host_we) shadow[host_addr] = host_wdata;
            else begin
                exp_rv = 1;
                exp_rd = shadow[host_addr];
            end
        end else if (host_req) wait_cnt++;
        srd = mem_re && !host_gnt;
        swb = mem_we && !host_gnt;
        if (srd) chk("scrub_rd_addr", 32'(mem_addr), 32'(exp_scrub));
        if (swb) begin
            chk("scrub_wb_addr", 32'(mem_addr), 32'(exp_scrub));
            chk("scrub_wb_data", 32'(mem_wdata), 32'(shadow[exp_scrub]));
            chk("scrub_addr_out", 32'(scrub_addr), 32'(exp_scrub));
            chk("pass_cnt", 32'(pass_cnt), 32'(exp_pass));
        end
        chk("pass_done", 32'(pass_done), 32'(swb && (exp_scrub == N - 1)));
        if (swb) begin
            if (exp_scrub == N - 1) exp_pass = (exp_pass + 1) % 65536;
            exp_scrub = (exp_scrub + 1) % N;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // kind 0: scrub read, kind 1: scrub writeback; returns positioned at the matching negedge
    task automatic wait_scrub(input int kind, input int limit, output bit hit);
        hit = 0;
        for (int i = 0; i < limit; i++) begin
            sample();
            if (kind == 0 ? (mem_re && !host_gnt) : (mem_we && !host_gnt)) begin
                hit = 1;
                break;
            end
            adv();
        end
    endtask

    initial begin
        // Reset with host_req asserted; preload the memory meanwhile.
        host_req = 1'b1;
        host_we  = 1'b1;
        for (int i = 0; i < N; i++) begin
            d = DW'($urandom);
            inj_vld = 1'b1;
            inj_addr = AW'(i);
            inj_d0 = d; inj_d1 = d; inj_d2 = d;
            sample();
            adv();
        end
        inj_vld = 1'b0;
        sample();
        chk("rst_strobes", 32'({host_gnt, host_rvalid, mem_we, mem_re, busy, pass_done}), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_scrub_addr", 32'(scrub_addr), 0);
        chk("rst_pass_cnt", 32'(pass_cnt), 0);
        adv();
        host_req = 1'b0;
        host_we  = 1'b0;
        rst_n    = 1'b1;

        // Scrub disabled: memory stays untouched.
        pd_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            sample();
            if (mem_re || mem_we) pd_cnt++;
            adv();
        end
        chk("idle_no_mem_access", 32'(pd_cnt), 0);

        // Host write then read-back.
        host_req = 1'b1; host_we = 1'b1; host_addr = 3; host_wdata = 8'hA5;
        sample();
        chk("wr_gnt", 32'(host_gnt), 1);
        chk("wr_mem_wdata", 32'(mem_wdata), 'hA5);
        adv();
        host_we = 1'b0;
        sample();
        chk("rd_gnt", 32'(host_gnt), 1);
        chk("rd_rvalid_early", 32'(host_rvalid), 0);
        adv();
        host_req = 1'b0;
        sample();
        chk("rd_rvalid", 32'(host_rvalid), 1);
        chk("rd_data", 32'(host_rdata), 'hA5);
        adv();
        sample();
        chk("rd_rvalid_once", 32'(host_rvalid), 0);
        adv();

        // Unloaded scrub: one read every SP cycles, writeback two cycles later, full pass.
        scrub_en = 1'b1;
        prev = 0;
        pd_cnt = 0;
        for (int k = 0; k < N; k++) begin
            wait_scrub(0, 20, ok);
            chk("scrub_rd_seen", 32'(ok), 1);
            chk("scrub_rd_n", 32'(mem_addr), k);
            if (k > 0) chk("scrub_interval", 32'(cyc - prev), SP);
            prev = cyc;
            adv();
            sample();
            chk("srd_no_access", 32'({mem_we, mem_re}), 0);
            chk("srd_busy", 32'(busy), 1);
            adv();
            sample();
            chk("swb_we", 32'(mem_we), 1);
            chk("swb_addr_n", 32'(mem_addr), k);
            if (pass_done) pd_cnt++;
            adv();
            if (k == N - 1) scrub_en = 1'b0;
        end
        sample();
        chk("pass_done_count", 32'(pd_cnt), 1);
        chk("pass_cnt_one", 32'(pass_cnt), 1);
        chk("scrub_addr_wrap", 32'(scrub_addr), 0);
        adv();
        for (int i = 0; i < 4; i++) begin sample(); adv(); end

        // Continuous host traffic: SP+MW grants, 3-cycle scrub, then 3 grants / 3 blocked steady state.
        scrub_en = 1'b1; host_req = 1'b1; host_we = 1'b0;
        host_addr = AW'($urandom); host_wdata = DW'($urandom);
        for (int i = 0; i < 19; i++) begin
            sample();
            chk("starve_gnt", 32'(host_gnt), 32'((i < SP + MW) || (i >= 10 && i < 13) || (i >= 16)));
            g = host_gnt;
            adv();
            if (g) begin
                host_we = ~host_we;
                host_addr = AW'($urandom);
                host_wdata = DW'($urandom);
            end
        end
        host_req = 1'b0;
        scrub_en = 1'b0;
        for (int i = 0; i < 6; i++) begin sample(); adv(); end

        // Single-copy upset at address 5 repaired by the scrub.
        inj_vld = 1'b1; inj_addr = 5; inj_d0 = 8'h00; inj_d1 = 8'h3C; inj_d2 = 8'h3C;
        sample();
        adv();
        inj_vld = 1'b0;
        scrub_en = 1'b1;
        found = 0;
        for (int i = 0; i < 120; i++) begin
            sample();
            if (mem_we && !host_gnt && mem_addr == 5) begin
                found = 1;
                chk("upset_wb_data", 32'(mem_wdata), 'h3C);
                break;
            end
            adv();
        end
        chk("upset_wb_seen", 32'(found), 1);
        adv();
        scrub_en = 1'b0;
        chk("upset_copy0", 32'(cp0[5]), 'h3C);
        chk("upset_copy1", 32'(cp1[5]), 'h3C);
        chk("upset_copy2", 32'(cp2[5]), 'h3C);
        for (int i = 0; i < 4; i++) begin sample(); adv(); end

        // Reset while in the scrub read-data cycle.
        scrub_en = 1'b1;
        wait_scrub(0, 40, ok);
        chk("mid_rst_rd_seen", 32'(ok), 1);
        adv();
        chk("mid_rst_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_scrub_addr", 32'(scrub_addr), 0);
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("mid_rst_no_we", 32'(mem_we), 0);
            adv();
        end
        rst_n = 1'b1;
        wait_scrub(0, 20, ok);
        chk("resume_rd_seen", 32'(ok), 1);
        chk("resume_addr", 32'(mem_addr), 0);
        adv();

        // Random host traffic with occasional scrub enable toggling.
        for (int i = 0; i < 3000; i++) begin
            sample();
            g = host_gnt;
            adv();
            if (g || !host_req) begin
                host_req   = ($urandom_range(0, 99) < 65);
                host_we    = 1'($urandom_range(0, 1));
                host_addr  = AW'($urandom);
                host_wdata = DW'($urandom);
            end
            if (scrub_en) begin
                if ($urandom_range(0, 299) == 0) scrub_en = 1'b0;
            end else if ($urandom_range(0, 9) == 0) scrub_en = 1'b1;
        end
        host_req = 1'b0;
        scrub_en = 1'b0;
        for (int i = 0; i < 6; i++) begin sample(); adv(); end
        chk("final_pass_cnt", 32'(pass_cnt), 32'(exp_pass));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmr_mem_scrub_ctrl.md
Name: tmr_mem_scrub_ctrl

Overview:
- Sequencer and arbiter in front of the TMR-protected memory. Shares the single memory port between a host requester and a background scrubber.
- The scrubber periodically reads each word (the voted value) and writes it back, which repairs single-copy upsets.
- Each scrub read-writeback pair is atomic. The host has priority, bounded by a scrub starvation limit.

Parameters:
- AW, 8, memory address width; scrub walks 0..2^AW-1.
- DW, 8, memory data width.
- SCRUB_PERIOD, 64, cycles between scrub ticks (>=2).
- MAX_WAIT, 16, cycles a pending scrub may be blocked by host traffic before it wins (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- scrub_en  in  1  enables the scrub timer.
- host_req  in  1  host access request; held with host_we/addr/wdata stable until host_gnt.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_gnt  out  1  access issued this cycle (combinational).
- host_rvalid  out  1  host read data valid (one cycle after a read grant).
- host_rdata  out  DW  equals mem_rdata; meaningful only while host_rvalid.
- mem_we  out  1  to memory write enable.
- mem_re  out  1  to memory read enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid the cycle after mem_re (registered read).
- scrub_addr  out  AW  next address to scrub.
- busy  out  1  scrub sequence in progress (state != IDLE).
- pass_done  out  1  one-cycle pulse when the writeback of address 2^AW-1 is issued.
- pass_cnt  out  16  completed scrub passes, wraps at 65535->0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; timer, pending, starve cnt, scrub_addr, pass_cnt all 0.
  - All outputs 0. No mem_we/mem_re asserted during reset.
- Timer:
  - While scrub_en=1, counts 0..SCRUB_PERIOD-1; at SCRUB_PERIOD-1 sets pending and wraps to 0.
  - Ticks arriving while pending=1 coalesce; they do not queue.
  - scrub_en=0 clears the timer and pending. A sequence already past IDLE still completes.
- States: IDLE, S_RD, S_WB.
- IDLE:
  - Scrub wins if pending=1 and (host_req=0 or starve>=MAX_WAIT). It then drives mem_re=1, mem_addr=scrub_addr, clears pending and starve, and goes to S_RD. host_gnt=0 that cycle.
  - Otherwise, if host_req=1: host_gnt=1, mem_addr=host_addr, and either mem_we=1 with mem_wdata=host_wdata, or mem_re=1. Stays in IDLE.
  - starve increments (saturating) each IDLE cycle with pending=1 and a host grant.
- S_RD:
  - No memory access; host_gnt=0.
  - Captures mem_rdata into the scrub data register; goes to S_WB.
- S_WB:
  - mem_we=1, mem_addr=scrub_addr, mem_wdata=captured data; host_gnt=0.
  - scrub_addr increments, wrapping 2^AW-1 -> 0.
  - On wrap: pass_done=1 and pass_cnt increments.
  - Returns to IDLE.
- Host read: host_rvalid=1 exactly one cycle after a read grant. Back-to-back host reads are allowed (one per cycle).
- Host read granted in the IDLE cycle immediately before a scrub read: host_rvalid/host_rdata are still correct, because the scrub read data is returned in S_RD.
- Host latency bound: the host waits at most 3 cycles per scrub (the scrub read cycle, S_RD, S_WB).
- Never mem_we and mem_re together. Never host_gnt outside IDLE.
- Reset asserted mid-sequence: immediate return to IDLE, and any half-done scrub is abandoned. Safe, because the memory word is unchanged until S_WB.

Test Plan:
- Reset, then idle: all outputs 0; with scrub_en=0, no mem_re/mem_we for 200 cycles.
- AW=4, SCRUB_PERIOD=4, scrub_en=1, no host traffic:
  - Every 4 cycles, mem_re at address n, writeback of the same data to n two cycles later.
  - After 16 scrubs: pass_done pulses once, pass_cnt=1, scrub_addr=0.
- Host write 0xA5 to addr 3, then read addr 3:
  - host_gnt on each request cycle.
  - host_rvalid the next cycle after the read grant, with host_rdata=0xA5.
- Scrub pending with host_req held continuously (alternating reads/writes), MAX_WAIT=3:
  - 3 host grants occur, then the scrub takes the port.
  - host_gnt stays 0 for 3 cycles, then host grants resume.
- Upset repair: force one TMR copy of addr 5 to 0x00 while the others hold 0x3C; let the scrub reach addr 5 -> writeback data 0x3C, and all three copies equal 0x3C afterward.
- rst_n pulsed low during S_RD:
  - busy drops immediately, no mem_we issued, scrub_addr=0.
  - After release, normal scrubbing resumes from addr 0.
